// File: rtl/sr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sr_arb_pkg
// Shared definitions for the SR flag arbiter slice: operation encoding,
// default sizing constants and the priority-pointer type for the default
// requester count.
// ---------------------------------------------------------------------------
package sr_arb_pkg;

    // Requester operation encoding carried on each op bit
    typedef enum logic {
        OP_RESET = 1'b0,
        OP_SET   = 1'b1
    } op_e;

    // Default number of requesters and conflict-counter width
    localparam int NREQ_DEFAULT = 4;
    localparam int CW_DEFAULT   = 8;

    // Round-robin priority pointer for the default requester count
    typedef logic [$clog2(NREQ_DEFAULT)-1:0] ptr_t;

endpackage

// File: rtl/sr_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
// Single SR flag storage cell. Set wins to 1, reset clears to 0, neither
// holds. Driving both at once is illegal and is caught by an assertion.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q
//   s    - set drive
//   r    - reset drive
//   q    - stored flag
//   qbar - inverse of q, valid at all times including reset
// ---------------------------------------------------------------------------
module sr_cell
    import sr_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
);

    logic r_q;

    // Flag storage; the arbiter guarantees s and r are never both high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (s) begin
            r_q <= 1'b1;
        end else if (r) begin
            r_q <= 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

    // Simultaneous set and reset must never reach the cell
    a_no_sr_both: assert property (@(posedge clk) disable iff (rst) !(s && r));

endmodule

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
// Round-robin arbiter sharing one SR flag cell between NREQ requesters.
// Each cycle one requester wins; its op becomes a registered set or reset
// pulse into the cell, so the flag follows two edges after the request.
//
// Parameters:
//   NREQ - number of requesters (>= 2)
//   CW   - width of the saturating conflict counter
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   req          - per-requester request, sampled every edge
//   op           - per-requester op, 1 = set, 0 = reset
//   gnt          - registered one-hot grant, one cycle per win
//   s_out        - registered set drive into the flag cell
//   r_out        - registered reset drive into the flag cell
//   q            - flag value
//   qbar         - inverse flag value
//   conflict_cnt - saturating count of cycles with two or more requests
// ---------------------------------------------------------------------------
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] gnt,
    output logic            s_out,
    output logic            r_out,
    output logic            q,
    output logic            qbar,
    output logic [CW-1:0]   conflict_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_s_out;
    logic            r_r_out;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_ptr_next;
    logic            w_found;
    logic            w_multi;
    int              w_idx;

    // Search requesters starting at the pointer and wrapping; the first
    // active request in that order wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[PW'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
        w_ptr_next = (int'(w_winner) == NREQ - 1) ? '0 : w_winner + 1'b1;
    end

    // Two or more requests: clearing the lowest set bit leaves something
    assign w_multi = |(req & (req - {{(NREQ-1){1'b0}}, 1'b1}));

    // Grant and cell drive registers; the winner moves to lowest priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_s_out <= 1'b0;
            r_r_out <= 1'b0;
        end else if (w_found) begin
            r_ptr   <= w_ptr_next;
            r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            r_s_out <= (op[w_winner] == OP_SET);
            r_r_out <= (op[w_winner] == OP_RESET);
        end else begin
            r_gnt   <= '0;
            r_s_out <= 1'b0;
            r_r_out <= 1'b0;
        end
    end

    // Conflict counter sticks at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_multi && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    sr_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .s    (r_s_out),
        .r    (r_r_out),
        .q    (q),
        .qbar (qbar)
    );

    assign gnt          = r_gnt;
    assign s_out        = r_s_out;
    assign r_out        = r_r_out;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Self-checking bench for sr_flag_arbiter with NREQ=4, CW=8. A behavioural
// model predicts every edge; predictions are queued when stimulus is driven
// and popped after the edge, alongside fixed expected sequences.
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            s;
        logic            r;
        logic            q;
        logic            qbar;
        logic [CW-1:0]   cnt;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] op  = '0;
    logic [NREQ-1:0] gnt;
    logic            s_out;
    logic            r_out;
    logic            q;
    logic            qbar;
    logic [CW-1:0]   conflict_cnt;

    int checks   = 0;
    int failures = 0;

    obs_t sbQueue[$];
    obs_t expItem;
    obs_t obsItem;

    // Reference model state
    logic [1:0]      mPtr;
    logic [NREQ-1:0] mGnt;
    logic            mS;
    logic            mR;
    logic            mQ;
    logic [CW-1:0]   mCnt;

    sr_flag_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .gnt          (gnt),
        .s_out        (s_out),
        .r_out        (r_out),
        .q            (q),
        .qbar         (qbar),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Clear the model and drop any stale predictions
    task automatic modelReset();
        mPtr = '0;
        mGnt = '0;
        mS   = 1'b0;
        mR   = 1'b0;
        mQ   = 1'b0;
        mCnt = '0;
        sbQueue.delete();
    endtask

    // Drive one cycle of stimulus and queue what the next edge must produce
    task automatic applyStimulus(input logic [NREQ-1:0] reqIn, input logic [NREQ-1:0] opIn);
        logic found;
        int   p;
        req = reqIn;
        op  = opIn;
        if (mS) mQ = 1'b1;
        else if (mR) mQ = 1'b0;
        if ($countones(reqIn) >= 2 && mCnt != 8'hFF) mCnt = mCnt + 8'd1;
        found = 1'b0;
        mGnt  = '0;
        mS    = 1'b0;
        mR    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            p = (int'(mPtr) + k) % NREQ;
            if (!found && reqIn[p]) begin
                found   = 1'b1;
                mGnt[p] = 1'b1;
                mS      = opIn[p];
                mR      = ~opIn[p];
                mPtr    = 2'((p + 1) % NREQ);
            end
        end
        sbQueue.push_back('{gnt: mGnt, s: mS, r: mR, q: mQ, qbar: ~mQ, cnt: mCnt});
    endtask

    // Advance one edge, sample away from it and pop the matching prediction
    task automatic tick();
        @(posedge clk);
        #1;
        obsItem = {gnt, s_out, r_out, q, qbar, conflict_cnt};
        if (sbQueue.size() > 0) expItem = sbQueue.pop_front();
        else expItem = 'x;
    endtask

    // Reset pulse released away from the clock edge
    task automatic doReset();
        rst = 1'b1;
        req = '0;
        op  = '0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1111, 4'b1111);
            tick();
            checks++;
            if (obsItem !== expItem) begin
                failures++;
                $display("[TB] FAIL reset_pre step %0d: got %h expected %h", i, obsItem, expItem);
            end
        end
        rst = 1'b1;
        modelReset();
        #1;
        for (int i = 0; i < 3; i++) begin
            obsItem = {gnt, s_out, r_out, q, qbar, conflict_cnt};
            checks++;
            if (obsItem !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
                failures++;
                $display("[TB] FAIL reset_hold step %0d: got %h expected %h", i, obsItem,
                         {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single_set();
        doReset();
        applyStimulus(4'b0001, 4'b0001);
        tick();
        checks++;
        if (obsItem !== expItem || gnt !== 4'b0001 || s_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_set_grant: got %h expected %h (gnt 0001, s_out 1)", obsItem, expItem);
        end
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checks++;
        if (obsItem !== expItem || q !== 1'b1 || qbar !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_set_q: got %h expected %h (q 1, qbar 0)", obsItem, expItem);
        end
        // Pointer moved to 1, so requester 1 beats requester 0
        applyStimulus(4'b0011, 4'b0000);
        tick();
        checks++;
        if (obsItem !== expItem || gnt !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_set_ptr: got gnt %b expected 0010", gnt);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] gntSeq [4];
        logic            qSeq   [4];
        gntSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        qSeq   = '{1'b1, 1'b0, 1'b1, 1'b0};
        doReset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) applyStimulus(4'b1111, 4'b0101);
            else applyStimulus(4'b0000, 4'b0000);
            tick();
            checks++;
            if (obsItem !== expItem) begin
                failures++;
                $display("[TB] FAIL contention_model step %0d: got %h expected %h", i, obsItem, expItem);
            end
            if (i < 4) begin
                checks++;
                if (gnt !== gntSeq[i]) begin
                    failures++;
                    $display("[TB] FAIL contention_gnt step %0d: got %b expected %b", i, gnt, gntSeq[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (q !== qSeq[i-1]) begin
                    failures++;
                    $display("[TB] FAIL contention_q step %0d: got %b expected %b", i, q, qSeq[i-1]);
                end
            end
        end
        checks++;
        if (conflict_cnt !== 8'd4) begin
            failures++;
            $display("[TB] FAIL contention_cnt: got %0d expected 4", conflict_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] gntSeq [2];
        gntSeq = '{4'b1000, 4'b0001};
        doReset();
        applyStimulus(4'b0100, 4'b0000);
        tick();
        checks++;
        if (obsItem !== expItem) begin
            failures++;
            $display("[TB] FAIL wrap_setup: got %h expected %h", obsItem, expItem);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1001, 4'b1001);
            tick();
            checks++;
            if (obsItem !== expItem || gnt !== gntSeq[i]) begin
                failures++;
                $display("[TB] FAIL wrap_gnt step %0d: got %b expected %b", i, gnt, gntSeq[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [NREQ-1:0] wantGnt;
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b0011, 4'b0001);
            tick();
            wantGnt = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (obsItem !== expItem || gnt !== wantGnt) begin
                failures++;
                $display("[TB] FAIL saturation step %0d: got %h expected %h", i, obsItem, expItem);
            end
        end
        checks++;
        if (conflict_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL saturation_final: got %0d expected 255", conflict_cnt);
        end
    endtask

    task automatic test_reset_midop();
        doReset();
        applyStimulus(4'b0001, 4'b0001);
        tick();
        checks++;
        if (obsItem !== expItem || s_out !== 1'b1 || q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_setup: got %h expected %h", obsItem, expItem);
        end
        rst = 1'b1;
        req = '0;
        modelReset();
        #1;
        checks++;
        if ({q, gnt, s_out} !== {1'b0, 4'b0000, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midop_immediate: got q=%b gnt=%b s_out=%b expected q=0 gnt=0000 s_out=0", q, gnt, s_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midop_discard: got q=%b expected 0", q);
        end
        rst = 1'b0;
        applyStimulus(4'b0100, 4'b0000);
        tick();
        checks++;
        if (obsItem !== expItem || gnt !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL midop_regrant: got gnt %b expected 0100", gnt);
        end
        applyStimulus(4'b1111, 4'b0000);
        tick();
        checks++;
        if (obsItem !== expItem || gnt !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL midop_next: got gnt %b expected 1000", gnt);
        end
    endtask

    // Run every scenario in turn, then report
    initial begin
        modelReset();
        #12;
        test_reset();
        test_single_set();
        test_contention();
        test_wrap();
        test_saturation();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
